pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//   Consumer side of the hazard-detection unit in the 5-stage MIPS pipeline (branches resolved in ID).
//   Takes the 2-bit hazard request and the ID-stage branch/jump decision, and sequences the
//   pipeline-register controls: PC hold, IF/ID hold, IF/ID flush and ID/EX bubble insertion.
//   A multi-cycle stall counter enforces the required bubble count.
//   Saturating performance counters record stall cycles and flushes.
// PARAMETERS
//   STALL_EX   2   bubbles for a hazard against the instruction in EX (req 2'b01); 0..3
//   STALL_MEM  1   bubbles for a hazard against the instruction in MEM (req 2'b11); 0..3
//   PERF_W     16  width of StallCycles and FlushCount
// PORTS
//   Clk           in   1       rising-edge clock
//   Rst_n         in   1       asynchronous, active-low reset
//   HazardReq     in   2       00 none, 01 EX-distance hazard, 11 MEM-distance hazard, 10 treated as 00
//   BranchTaken   in   1       branch/jump taken, resolved in ID this cycle
//   PCWrite       out  1       1 = PC loads next value
//   IF_ID_Write   out  1       1 = IF/ID register loads
//   IF_ID_Flush   out  1       1 = IF/ID loaded with NOP
//   ID_EX_Bubble  out  1       1 = ID/EX control fields zeroed (NOP)
//   Stalling      out  1       1 = FSM in STALL state (registered)
//   StallCycles   out  PERF_W  saturating count of cycles with ID_EX_Bubble=1
//   FlushCount    out  PERF_W  saturating count of cycles with IF_ID_Flush=1
// BEHAVIOUR
//   Reset (Rst_n=0, async):
//   - State -> RUN; stall counter, StallCycles and FlushCount -> 0; Stalling=0.
//   - Outputs forced while Rst_n=0: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1.
//   - Performance counters do not count during reset.
//   FSM states: RUN, STALL. Stall counter width 2. Control outputs are combinational (0-cycle latency).
//   RUN:
//   - N = STALL_EX for req 01, STALL_MEM for req 11, 0 otherwise.
//   - N>0: this cycle PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
//   - N>1: load counter with N-2 and go to STALL. N==1: stay in RUN.
//   - N==0 and BranchTaken=1: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=0.
//   - N==0 and BranchTaken=0: PCWrite=1, IF_ID_Write=1, flush=0, bubble=0.
//   STALL:
//   - PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
//   - HazardReq and BranchTaken are ignored.
//   - Counter==0: next state RUN. Otherwise decrement the counter.
//   - Total bubbles per accepted request = N, on exactly N consecutive cycles.
//   Priority rules:
//   - A hazard beats a same-cycle BranchTaken; the branch operands are stale, so no flush.
//   - The hazard unit re-presents the branch after the stall.
//   - A request arriving in the first RUN cycle after STALL is accepted normally.
//   Counters:
//   - StallCycles increments on every clock edge where ID_EX_Bubble=1 and Rst_n=1.
//   - FlushCount increments on every clock edge where IF_ID_Flush=1 and Rst_n=1.
//   - Both saturate at all-ones (no wrap).
//   - Arithmetic is unsigned; the stall counter never underflows.
//   Reset mid-STALL: immediate return to RUN. After release, PCWrite=1 on the first cycle with req 00.
// TESTING
//   1. Defaults; req=01 for 1 cycle at t0 -> Bubble=1, PCWrite=0 at t0, t1; Stalling=1 at t1 only;
//      PCWrite=1 at t2; StallCycles=2.
//   2. req=11 for 1 cycle -> exactly 1 bubble; Stalling stays 0; StallCycles=1.
//   3. BranchTaken=1, req=00 -> IF_ID_Flush=1, PCWrite=1, Bubble=0 that cycle; FlushCount=1.
//   4. req=01 with BranchTaken=1 at t0, BranchTaken=1 again at t1 -> 2 bubbles, IF_ID_Flush never 1,
//      FlushCount=0.
//   5. Rst_n low during t1 of a req=01 stall -> Stalling=0 and counters=0 immediately;
//      after release with req=00 -> PCWrite=1.
//   6. PERF_W=4; twenty single-cycle req=11 pulses -> StallCycles=15 (saturated, no wrap).

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: turns hazard requests and ID-stage
// branch decisions into PC / IF-ID / ID-EX register controls, with saturating perf counters.
module pipeline_stall_ctrl #(
  parameter int unsigned STALL_EX  = 2,
  parameter int unsigned STALL_MEM = 1,
  parameter int unsigned PERF_W    = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [1:0]        HazardReq,
  input  logic              BranchTaken,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Bubble,
  output logic              Stalling,
  output logic [PERF_W-1:0] StallCycles,
  output logic [PERF_W-1:0] FlushCount
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [1:0] N_EX  = 2'(STALL_EX);
  localparam logic [1:0] N_MEM = 2'(STALL_MEM);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        req_n;
  logic              pc_w, ifid_w, flush, bubble;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    case (HazardReq)
      2'b01:   req_n = N_EX;
      2'b11:   req_n = N_MEM;
      default: req_n = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    flush   = 1'b0;
    bubble  = 1'b0;
    case (state_q)
      RUN: begin
        // A hazard wins over a same-cycle branch: its operands are stale, so no flush.
        if (req_n != 2'd0) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          bubble = 1'b1;
          if (req_n > 2'd1) begin
            cnt_d   = req_n - 2'd2;
            state_d = STALL;
          end
        end else if (BranchTaken) begin
          flush = 1'b1;
        end
      end
      STALL: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        bubble = 1'b1;
        if (cnt_q == 2'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (bubble && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    if (flush && (flush_count_q != '1))   flush_count_d  = flush_count_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // While in reset the pipeline registers are held and filled with NOPs.
  always_comb begin
    PCWrite      = Rst_n & pc_w;
    IF_ID_Write  = Rst_n & ifid_w;
    IF_ID_Flush  = ~Rst_n | flush;
    ID_EX_Bubble = ~Rst_n | bubble;
  end

  assign Stalling    = (state_q == STALL);
  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: three parameterisations driven in lockstep and checked
// against a remaining-bubble model with saturating counters.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic       br = 1'b0;

  logic [2:0] pcw, ifw, fl, bub, stl;
  logic [15:0] sc0, fc0, sc2, fc2;
  logic [3:0]  sc1, fc1;

  int checks = 0;
  int errors = 0;

  // Model configuration per instance: EX bubbles, MEM bubbles, counter width.
  int nex  [3] = '{2, 2, 3};
  int nmem [3] = '{1, 1, 2};
  int wid  [3] = '{16, 4, 16};
  int rem  [3];
  int msc  [3];
  int mfc  [3];

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut0 (
    .Clk(clk), .Rst_n(rst_n), .HazardReq(req), .BranchTaken(br),
    .PCWrite(pcw[0]), .IF_ID_Write(ifw[0]), .IF_ID_Flush(fl[0]), .ID_EX_Bubble(bub[0]),
    .Stalling(stl[0]), .StallCycles(sc0), .FlushCount(fc0)
  );

  pipeline_stall_ctrl #(.STALL_EX(2), .STALL_MEM(1), .PERF_W(4)) dut1 (
    .Clk(clk), .Rst_n(rst_n), .HazardReq(req), .BranchTaken(br),
    .PCWrite(pcw[1]), .IF_ID_Write(ifw[1]), .IF_ID_Flush(fl[1]), .ID_EX_Bubble(bub[1]),
    .Stalling(stl[1]), .StallCycles(sc1), .FlushCount(fc1)
  );

  pipeline_stall_ctrl #(.STALL_EX(3), .STALL_MEM(2), .PERF_W(16)) dut2 (
    .Clk(clk), .Rst_n(rst_n), .HazardReq(req), .BranchTaken(br),
    .PCWrite(pcw[2]), .IF_ID_Write(ifw[2]), .IF_ID_Flush(fl[2]), .ID_EX_Bubble(bub[2]),
    .Stalling(stl[2]), .StallCycles(sc2), .FlushCount(fc2)
  );

  function automatic logic [15:0] get_sc(int i);
    case (i)
      0:       return sc0;
      1:       return {12'h000, sc1};
      default: return sc2;
    endcase
  endfunction

  function automatic logic [15:0] get_fc(int i);
    case (i)
      0:       return fc0;
      1:       return {12'h000, fc1};
      default: return fc2;
    endcase
  endfunction

  function automatic int n_of(int i, logic [1:0] r);
    if (r == 2'b01) return nex[i];
    if (r == 2'b11) return nmem[i];
    return 0;
  endfunction

  function automatic int sat(int x, int w);
    int mx = (1 << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic chk_regs();
    for (int i = 0; i < 3; i++) begin
      chk("Stalling", i, 32'(stl[i]), 32'(rem[i] > 0));
      chk("StallCycles", i, 32'(get_sc(i)), 32'(sat(msc[i], wid[i])));
      chk("FlushCount", i, 32'(get_fc(i)), 32'(sat(mfc[i], wid[i])));
    end
  endtask

  // One clock cycle: drive inputs after a falling edge, check the combinational
  // controls, let the rising edge happen, then check registered state.
  task automatic step(input logic [1:0] r, input logic b);
    logic e_bub [3];
    logic e_fl  [3];
    req = r;
    br  = b;
    #1;
    for (int i = 0; i < 3; i++) begin
      e_bub[i] = (rem[i] > 0) || (n_of(i, r) > 0);
      e_fl[i]  = !e_bub[i] && b;
      chk("ID_EX_Bubble", i, 32'(bub[i]), 32'(e_bub[i]));
      chk("PCWrite", i, 32'(pcw[i]), 32'(!e_bub[i]));
      chk("IF_ID_Write", i, 32'(ifw[i]), 32'(!e_bub[i]));
      chk("IF_ID_Flush", i, 32'(fl[i]), 32'(e_fl[i]));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rem[i] > 0) rem[i]--;
      else if (n_of(i, r) > 0) rem[i] = n_of(i, r) - 1;
      if (e_bub[i]) msc[i]++;
      if (e_fl[i]) mfc[i]++;
    end
    @(negedge clk);
    chk_regs();
  endtask

  // Asserted at a falling edge (mid-cycle) and held across one rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      rem[i] = 0;
      msc[i] = 0;
      mfc[i] = 0;
      chk("rst_PCWrite", i, 32'(pcw[i]), 32'd0);
      chk("rst_IF_ID_Write", i, 32'(ifw[i]), 32'd0);
      chk("rst_IF_ID_Flush", i, 32'(fl[i]), 32'd1);
      chk("rst_ID_EX_Bubble", i, 32'(bub[i]), 32'd1);
    end
    chk_regs();
    @(negedge clk);
    chk_regs();
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Single EX-distance hazard: two bubbles, Stalling on the second only.
    step(2'b01, 1'b0);
    chk("t1_Stalling", 0, 32'(stl[0]), 32'd1);
    step(2'b00, 1'b0);
    chk("t1_Stalling_end", 0, 32'(stl[0]), 32'd0);
    step(2'b00, 1'b0);
    chk("t1_StallCycles", 0, 32'(sc0), 32'd2);

    // MEM-distance hazard: exactly one bubble, never Stalling.
    do_reset();
    step(2'b11, 1'b0);
    chk("t2_Stalling", 0, 32'(stl[0]), 32'd0);
    step(2'b00, 1'b0);
    chk("t2_StallCycles", 0, 32'(sc0), 32'd1);

    // Taken branch with no hazard flushes IF/ID.
    do_reset();
    step(2'b00, 1'b1);
    chk("t3_FlushCount", 0, 32'(fc0), 32'd1);

    // Hazard beats a same-cycle branch, and the branch is ignored while stalled.
    do_reset();
    step(2'b01, 1'b1);
    step(2'b00, 1'b1);
    chk("t4_FlushCount", 0, 32'(fc0), 32'd0);
    chk("t4_StallCycles", 0, 32'(sc0), 32'd2);

    // Reset in the middle of a stall, then normal operation.
    do_reset();
    step(2'b01, 1'b0);
    do_reset();
    step(2'b00, 1'b0);

    // Back-to-back hazards and 10 treated as none.
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    step(2'b11, 1'b0);
    step(2'b10, 1'b1);

    // Twenty MEM-distance pulses saturate the 4-bit counters.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(2'b11, 1'b0);
      step(2'b00, 1'b0);
    end
    chk("t6_StallCycles_w4", 1, 32'(sc1), 32'd15);
    chk("t6_StallCycles_w16", 0, 32'(sc0), 32'd20);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
